mem_arbiter: RTL and testbench

Arbitrates a single-port, fixed-latency memory between the fetch stage's instruction read port and the memory stage's data load/store port. This lets the pipeline run from one unified instruction and data RAM instead of two separate arrays. The block sits between the pipeline's memory-side request ports and the shared `ram` instance. It sequences each access through an issue/wait/response state machine and returns read data with a one-cycle valid pulse.

---
 rtl/mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency, single-port memory between the
// instruction fetch read port and the data load/store port.
// Each access walks IDLE -> ISSUE -> (WAIT -> RESP) and returns read data
// with a one-cycle valid pulse. Stores finish in their ISSUE cycle.
// Optional build macro MEM_ARB_RR_EN selects round-robin arbitration on
// conflicts. Without it, the data port always wins a conflict.
// Every output comes from a flop. There is no path from a request input
// straight through to an output.
module mem_arbiter #(
  parameter int DATA_WIDTH  = 64,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // instruction read port
  input  logic                  i_req_i,
  input  logic [DATA_WIDTH-1:0] i_adr_i,
  output logic                  i_gnt_o,
  output logic                  i_rvalid_o,
  output logic [31:0]           i_rdata_o,
  // data load/store port
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [DATA_WIDTH-1:0] d_adr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  // shared memory side
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_adr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o
);

  // Value loaded into the latency counter in ISSUE. WAIT ends when the
  // counter reaches zero.
  localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [3:0] cnt, cnt_nxt;

  // Command fields captured when an access enters ISSUE.
  logic cmd_d, cmd_d_nxt;       // 1 = data port owns the access
  logic cmd_we, cmd_we_nxt;     // 1 = store
  logic cmd_half, cmd_half_nxt; // instruction word comes from the upper half

  // Next values for the registered outputs.
  logic                  i_gnt_nxt, d_gnt_nxt;
  logic                  i_rvalid_nxt, d_rvalid_nxt;
  logic [31:0]           i_rdata_nxt;
  logic [DATA_WIDTH-1:0] d_rdata_nxt;
  logic                  mem_en_nxt, mem_we_nxt;
  logic [DATA_WIDTH-1:0] mem_adr_nxt, mem_wdata_nxt;
  logic                  busy_nxt;

  // Arbitration decision.
  logic arb_point;
  logic d_cand, i_cand;
  logic pick_d;
  logic launch;
  logic capture;

`ifdef MEM_ARB_RR_EN
  logic last_d, last_d_nxt;
`endif

  // The low address bits are not needed. The memory is word addressed, and
  // only bit 2 picks the instruction half.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{i_adr_i[1:0], d_adr_i[2:0]};

  // Decide whether this cycle can start a new access, and which port gets it.
  always_comb begin
    arb_point = 1'b0;
    case (state)
      IDLE:    arb_point = 1'b1;
      ISSUE:   arb_point = cmd_we;
      RESP:    arb_point = 1'b1;
      default: arb_point = 1'b0;
    endcase
    // In a store's ISSUE cycle, d_req_i is still high for the store being
    // granted now. That request must not be issued a second time.
    if (state == ISSUE) begin
      d_cand = 1'b0;
    end else begin
      d_cand = d_req_i;
    end
    i_cand = i_req_i;
`ifdef MEM_ARB_RR_EN
    pick_d = d_cand & (~i_cand | ~last_d);
`else
    pick_d = d_cand;
`endif
    launch = arb_point & (d_cand | i_cand);
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (launch) begin
          state_nxt = ISSUE;
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (!cmd_we) begin
          state_nxt = WAIT;
        end else if (launch) begin
          state_nxt = ISSUE;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
        end else begin
          state_nxt = WAIT;
        end
      end
      RESP: begin
        if (launch) begin
          state_nxt = ISSUE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Compute the next value of each registered output, the counter, and the
  // command fields.
  always_comb begin
    i_gnt_nxt  = launch & ~pick_d;
    d_gnt_nxt  = launch & pick_d;
    mem_en_nxt = launch;
    mem_we_nxt = launch & pick_d & d_we_i;

    if (launch) begin
      if (pick_d) begin
        mem_adr_nxt = {d_adr_i[DATA_WIDTH-1:3], 3'b000};
      end else begin
        mem_adr_nxt = {i_adr_i[DATA_WIDTH-1:3], 3'b000};
      end
    end else begin
      mem_adr_nxt = '0;
    end

    if (mem_we_nxt) begin
      mem_wdata_nxt = d_wdata_i;
    end else begin
      mem_wdata_nxt = '0;
    end

    // Memory data is valid in the last WAIT cycle.
    capture      = (state == WAIT) && (cnt == 4'd0);
    i_rvalid_nxt = capture & ~cmd_d;
    d_rvalid_nxt = capture & cmd_d;

    if (i_rvalid_nxt) begin
      if (cmd_half) begin
        i_rdata_nxt = mem_rdata_i[32 +: 32];
      end else begin
        i_rdata_nxt = mem_rdata_i[0 +: 32];
      end
    end else begin
      i_rdata_nxt = i_rdata_o;
    end

    if (d_rvalid_nxt) begin
      d_rdata_nxt = mem_rdata_i;
    end else begin
      d_rdata_nxt = d_rdata_o;
    end

    if (state == ISSUE) begin
      cnt_nxt = LAT_LOAD;
    end else if ((state == WAIT) && (cnt != 4'd0)) begin
      cnt_nxt = cnt - 4'd1;
    end else begin
      cnt_nxt = cnt;
    end

    if (launch) begin
      cmd_d_nxt    = pick_d;
      cmd_we_nxt   = pick_d & d_we_i;
      cmd_half_nxt = ~pick_d & i_adr_i[2];
    end else begin
      cmd_d_nxt    = cmd_d;
      cmd_we_nxt   = cmd_we;
      cmd_half_nxt = cmd_half;
    end

`ifdef MEM_ARB_RR_EN
    if (launch) begin
      last_d_nxt = pick_d;
    end else begin
      last_d_nxt = last_d;
    end
`endif

    busy_nxt = (state_nxt != IDLE);
  end

  // Register the outputs, the latency counter, and the command fields.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      i_gnt_o     <= 1'b0;
      d_gnt_o     <= 1'b0;
      i_rvalid_o  <= 1'b0;
      d_rvalid_o  <= 1'b0;
      i_rdata_o   <= 32'd0;
      d_rdata_o   <= '0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_adr_o   <= '0;
      mem_wdata_o <= '0;
      busy_o      <= 1'b0;
      cnt         <= 4'd0;
      cmd_d       <= 1'b0;
      cmd_we      <= 1'b0;
      cmd_half    <= 1'b0;
    end else begin
      i_gnt_o     <= i_gnt_nxt;
      d_gnt_o     <= d_gnt_nxt;
      i_rvalid_o  <= i_rvalid_nxt;
      d_rvalid_o  <= d_rvalid_nxt;
      i_rdata_o   <= i_rdata_nxt;
      d_rdata_o   <= d_rdata_nxt;
      mem_en_o    <= mem_en_nxt;
      mem_we_o    <= mem_we_nxt;
      mem_adr_o   <= mem_adr_nxt;
      mem_wdata_o <= mem_wdata_nxt;
      busy_o      <= busy_nxt;
      cnt         <= cnt_nxt;
      cmd_d       <= cmd_d_nxt;
      cmd_we      <= cmd_we_nxt;
      cmd_half    <= cmd_half_nxt;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Remember which port won the most recent grant, for round-robin.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_d <= 1'b0;
    end else begin
      last_d <= last_d_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter.
// Main DUT uses MEM_LATENCY=1 and runs table vectors, a store-then-fetch
// sequence, and a contention run. A second DUT uses MEM_LATENCY=4 for the
// reset-during-WAIT check. Read data goes through scoreboard queues.
module tb_mem_arbiter;
  localparam int DW = 64;
  localparam logic [63:0] POISON = 64'hBAD0_BAD0_BAD0_BAD0;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // main DUT signals
  logic rst, i_req, i_gnt, i_rvalid, d_req, d_we, d_gnt, d_rvalid;
  logic mem_en, mem_we, busy;
  logic [DW-1:0] i_adr, d_adr, d_wdata, d_rdata, mem_adr, mem_wdata, mem_rdata;
  logic [31:0] i_rdata;

  // latency-4 DUT signals
  logic rst4, i4_req, i4_gnt, i4_rvalid, mem4_en, busy4;
  logic [DW-1:0] i4_adr, mem4_adr, mem4_rdata;
  logic [31:0] i4_rdata;
  logic d4_req, d4_we;
  logic [DW-1:0] d4_adr, d4_wdata;
  logic d4_gnt, d4_rvalid, unused_mem4_we;
  logic [DW-1:0] d4_rdata, unused_mem4_wdata;

  mem_arbiter #(.DATA_WIDTH(DW), .MEM_LATENCY(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .i_req_i(i_req), .i_adr_i(i_adr), .i_gnt_o(i_gnt), .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_adr_i(d_adr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_adr_o(mem_adr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  mem_arbiter #(.DATA_WIDTH(DW), .MEM_LATENCY(4)) dut4 (
    .clk_i(clk), .rst_i(rst4),
    .i_req_i(i4_req), .i_adr_i(i4_adr), .i_gnt_o(i4_gnt), .i_rvalid_o(i4_rvalid), .i_rdata_o(i4_rdata),
    .d_req_i(d4_req), .d_we_i(d4_we), .d_adr_i(d4_adr), .d_wdata_i(d4_wdata),
    .d_gnt_o(d4_gnt), .d_rvalid_o(d4_rvalid), .d_rdata_o(d4_rdata),
    .mem_en_o(mem4_en), .mem_we_o(unused_mem4_we), .mem_adr_o(mem4_adr), .mem_wdata_o(unused_mem4_wdata),
    .mem_rdata_i(mem4_rdata), .busy_o(busy4)
  );

  // Shared memory array: preload port plus writes from the main DUT.
  logic [63:0] mem [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_idx = 10'd0;
  logic [63:0] pre_data = 64'd0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (mem_en && mem_we) mem[mem_adr[12:3]] <= mem_wdata;
  end

  // Latency-1 read path for the main DUT.
  logic [63:0] rd1;
  always @(posedge clk) rd1 <= mem_en ? mem[mem_adr[12:3]] : POISON;
  assign mem_rdata = rd1;

  // Latency-4 read path for dut4.
  logic [63:0] pipe4 [4];
  always @(posedge clk) begin
    pipe4[0] <= mem4_en ? mem[mem4_adr[12:3]] : POISON;
    for (int k = 1; k < 4; k++) pipe4[k] <= pipe4[k-1];
  end
  assign mem4_rdata = pipe4[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard
  typedef struct { logic [63:0] data; int due; } exp_t;
  exp_t i_q[$];
  exp_t d_q[$];
  bit   gnt_log[$];

  task automatic push_i(input logic [63:0] data, input int due);
    exp_t e; e.data = data; e.due = due; i_q.push_back(e);
  endtask
  task automatic push_d(input logic [63:0] data, input int due);
    exp_t e; e.data = data; e.due = due; d_q.push_back(e);
  endtask

  // Monitor: pop expected read data on each rvalid and log grant order.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (i_rvalid) begin
        if (i_q.size() == 0) chk("spurious_i_rvalid", {63'd0, i_rvalid}, 64'd0);
        else begin
          e = i_q.pop_front();
          chk("i_rdata", {32'd0, i_rdata}, e.data);
          if (e.due >= 0) chk("i_rvalid_cycle", 64'(cyc), 64'(e.due));
        end
      end
      if (d_rvalid) begin
        if (d_q.size() == 0) chk("spurious_d_rvalid", {63'd0, d_rvalid}, 64'd0);
        else begin
          e = d_q.pop_front();
          chk("d_rdata", d_rdata, e.data);
          if (e.due >= 0) chk("d_rvalid_cycle", 64'(cyc), 64'(e.due));
        end
      end
      if (i_gnt || d_gnt) chk("dual_grant", {63'd0, i_gnt & d_gnt}, 64'd0);
      if (d_gnt) gnt_log.push_back(1'b1);
      else if (i_gnt) gnt_log.push_back(1'b0);
    end
  end

  task automatic preload(input logic [63:0] adr, input logic [63:0] data);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = adr[12:3]; pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic check_main_reset(input string tag);
    chk({tag, "_i_gnt"}, {63'd0, i_gnt}, 64'd0);
    chk({tag, "_i_rvalid"}, {63'd0, i_rvalid}, 64'd0);
    chk({tag, "_i_rdata"}, {32'd0, i_rdata}, 64'd0);
    chk({tag, "_d_gnt"}, {63'd0, d_gnt}, 64'd0);
    chk({tag, "_d_rvalid"}, {63'd0, d_rvalid}, 64'd0);
    chk({tag, "_d_rdata"}, d_rdata, 64'd0);
    chk({tag, "_mem_en"}, {63'd0, mem_en}, 64'd0);
    chk({tag, "_mem_we"}, {63'd0, mem_we}, 64'd0);
    chk({tag, "_mem_adr"}, mem_adr, 64'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  typedef struct { bit is_d; bit we; logic [63:0] adr; logic [63:0] wdata; logic [63:0] exp; } vec_t;

  // One isolated access from IDLE: grant at c+1, rvalid at c+3.
  task automatic apply_vec(input vec_t v);
    int c;
    @(negedge clk);
    c = cyc;
    if (v.is_d) begin d_req = 1'b1; d_we = v.we; d_adr = v.adr; d_wdata = v.wdata; end
    else begin i_req = 1'b1; i_adr = v.adr; end
    if (!v.we) begin
      if (v.is_d) push_d(v.exp, c + 3); else push_i(v.exp, c + 3);
    end
    @(negedge clk);
    chk("own_gnt", {63'd0, v.is_d ? d_gnt : i_gnt}, 64'd1);
    chk("other_gnt", {63'd0, v.is_d ? i_gnt : d_gnt}, 64'd0);
    chk("mem_en_issue", {63'd0, mem_en}, 64'd1);
    chk("mem_we_issue", {63'd0, mem_we}, {63'd0, v.we});
    chk("mem_adr_issue", mem_adr, v.adr & ~64'h7);
    if (v.we) chk("mem_wdata_issue", mem_wdata, v.wdata);
    chk("busy_issue", {63'd0, busy}, 64'd1);
    d_req = 1'b0; i_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("mem_en_after", {63'd0, mem_en}, 64'd0);
    chk("mem_we_after", {63'd0, mem_we}, 64'd0);
    repeat (3) begin
      @(negedge clk);
      if (v.we) chk("store_no_rvalid", {63'd0, d_rvalid}, 64'd0);
    end
    chk("busy_idle", {63'd0, busy}, 64'd0);
  endtask

  // Data port: three back-to-back loads with d_req held high throughout.
  task automatic drv_d_loads();
    logic [63:0] adrs [3] = '{64'h1000, 64'h1008, 64'h40};
    logic [63:0] exps [3] = '{64'h1111_2222_3333_4444, 64'hCAFE_BABE_0BAD_F00D, 64'h0000_0000_0000_DEAD};
    int t;
    for (int k = 0; k < 3; k++) begin
      d_req = 1'b1; d_we = 1'b0; d_adr = adrs[k];
      push_d(exps[k], -1);
      t = 0;
      do begin @(negedge clk); t++; end while (!d_gnt && t < 50);
      if (!d_gnt) chk("d_gnt_timeout", {63'd0, d_gnt}, 64'd1);
    end
    d_req = 1'b0;
  endtask

  // Instruction port: two reads with i_req held high throughout.
  task automatic drv_i_reads();
    logic [63:0] adrs [2] = '{64'h1004, 64'h100C};
    logic [63:0] exps [2] = '{64'h1111_2222, 64'hCAFE_BABE};
    int t;
    for (int k = 0; k < 2; k++) begin
      i_req = 1'b1; i_adr = adrs[k];
      push_i(exps[k], -1);
      t = 0;
      do begin @(negedge clk); t++; end while (!i_gnt && t < 80);
      if (!i_gnt) chk("i_gnt_timeout", {63'd0, i_gnt}, 64'd1);
    end
    i_req = 1'b0;
  endtask

  // dut4 read: rvalid expected exactly MEM_LATENCY+2 = 6 cycles after request.
  task automatic dut4_read(input logic [63:0] adr, input logic [63:0] exp);
    int c, t;
    @(negedge clk);
    c = cyc; i4_req = 1'b1; i4_adr = adr;
    @(negedge clk);
    chk("l4_gnt", {63'd0, i4_gnt}, 64'd1);
    i4_req = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!i4_rvalid && t < 20);
    chk("l4_rvalid_seen", {63'd0, i4_rvalid}, 64'd1);
    chk("l4_rvalid_cycle", 64'(cyc), 64'(c + 6));
    chk("l4_rdata", {32'd0, i4_rdata}, exp);
  endtask

  vec_t vecs [9];

  initial begin
    int c0;
    bit exp_seq [5];
    vecs[0] = '{1'b0, 1'b0, 64'h1004, 64'h0, 64'h1111_2222};
    vecs[1] = '{1'b0, 1'b0, 64'h1000, 64'h0, 64'h3333_4444};
    vecs[2] = '{1'b1, 1'b1, 64'h40, 64'hDEAD, 64'h0};
    vecs[3] = '{1'b1, 1'b0, 64'h40, 64'h0, 64'hDEAD};
    vecs[4] = '{1'b1, 1'b0, 64'h1000, 64'h0, 64'h1111_2222_3333_4444};
    vecs[5] = '{1'b1, 1'b1, 64'h1008, 64'hCAFE_BABE_0BAD_F00D, 64'h0};
    vecs[6] = '{1'b0, 1'b0, 64'h100C, 64'h0, 64'hCAFE_BABE};
    vecs[7] = '{1'b1, 1'b0, 64'h1008, 64'h0, 64'hCAFE_BABE_0BAD_F00D};
    vecs[8] = '{1'b0, 1'b0, 64'h1008, 64'h0, 64'h0BAD_F00D};
`ifdef MEM_ARB_RR_EN
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`endif

    rst = 1'b1; rst4 = 1'b1;
    i_req = 1'b0; i_adr = '0; d_req = 1'b0; d_we = 1'b0; d_adr = '0; d_wdata = '0;
    i4_req = 1'b0; i4_adr = '0; d4_req = 1'b0; d4_we = 1'b0; d4_adr = '0; d4_wdata = '0;

    preload(64'h1000, 64'h1111_2222_3333_4444);
    @(negedge clk);
    check_main_reset("reset");
    rst = 1'b0; rst4 = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 9; k++) apply_vec(vecs[k]);

    // Store issued with an instruction read arriving in its ISSUE cycle.
    @(negedge clk);
    c0 = cyc;
    d_req = 1'b1; d_we = 1'b1; d_adr = 64'h48; d_wdata = 64'h55;
    @(negedge clk);
    chk("seqA_store_gnt", {63'd0, d_gnt}, 64'd1);
    chk("seqA_store_we", {63'd0, mem_we}, 64'd1);
    d_req = 1'b0; d_we = 1'b0;
    i_req = 1'b1; i_adr = 64'h1004;
    push_i(64'h1111_2222, c0 + 4);
    @(negedge clk);
    chk("seqA_i_gnt", {63'd0, i_gnt}, 64'd1);
    chk("seqA_i_mem_adr", mem_adr, 64'h1000);
    i_req = 1'b0;
    repeat (4) @(negedge clk);
    apply_vec('{1'b1, 1'b0, 64'h48, 64'h0, 64'h55});

    // Reset restores arbitration state, then both ports contend.
    @(negedge clk);
    rst = 1'b1;
    gnt_log.delete();
    @(negedge clk);
    check_main_reset("reset2");
    rst = 1'b0;
    @(negedge clk);
    fork
      drv_d_loads();
      drv_i_reads();
    join
    repeat (6) @(negedge clk);
    chk("grant_count", 64'(gnt_log.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < gnt_log.size()) chk("grant_order", {63'd0, gnt_log[k]}, {63'd0, exp_seq[k]});
    end

    // Latency 4: a full read, then reset in the second WAIT cycle.
    dut4_read(64'h1004, 64'h1111_2222);
    @(negedge clk);
    i4_req = 1'b1; i4_adr = 64'h1000;
    @(negedge clk);
    chk("l4r_gnt", {63'd0, i4_gnt}, 64'd1);
    i4_req = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst4 = 1'b1;
    #1;
    chk("l4r_busy", {63'd0, busy4}, 64'd0);
    chk("l4r_mem_en", {63'd0, mem4_en}, 64'd0);
    chk("l4r_mem_adr", mem4_adr, 64'd0);
    chk("l4r_i_rdata", {32'd0, i4_rdata}, 64'd0);
    chk("l4r_i_rvalid", {63'd0, i4_rvalid}, 64'd0);
    chk("l4r_i_gnt", {63'd0, i4_gnt}, 64'd0);
    chk("l4r_d_outs", {61'd0, d4_gnt, d4_rvalid, |d4_rdata}, 64'd0);
    @(negedge clk);
    rst4 = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("l4r_no_rvalid", {63'd0, i4_rvalid}, 64'd0);
    end
    dut4_read(64'h100C, 64'hCAFE_BABE);

    chk("i_q_drained", 64'(i_q.size()), 64'd0);
    chk("d_q_drained", 64'(d_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
